// File: rtl/button_event_decoder.sv
// ---------------------------------------------------------------------------
// button_event_decoder
//
// Turns debounced button levels into one-cycle event pulses for the stopwatch
// control FSM. Every lane has its own sample register, hold counter and
// IDLE/PRESSED/LONG state machine. All outputs are registered.
//
// Optional feature macro: BTN_AUTOREPEAT_EN
//   defined   - LONG state runs a repeat counter and pulses o_repeat_evt
//   undefined - repeat logic absent, o_repeat_evt tied to 0
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst          asynchronous active-high reset
//   i_buttons      debounced levels, 1 = pressed (lane 0 = START)
//   o_held         registered copy of i_buttons
//   o_press        one-cycle pulse when a press is recognised
//   o_release      one-cycle pulse when a release is recognised
//   o_long_press   one-cycle pulse when a hold reaches LONG_CYCLES
//   o_repeat_evt   one-cycle auto-repeat pulse every REPEAT_CYCLES in LONG
// ---------------------------------------------------------------------------
module button_event_decoder #(
  parameter int unsigned NUM_BUTTONS   = 5,
  parameter int unsigned CNT_WIDTH     = 27,
  parameter int unsigned LONG_CYCLES   = 100_000_000,
  parameter int unsigned REPEAT_CYCLES = 20_000_000
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NUM_BUTTONS-1:0] i_buttons,
  output logic [NUM_BUTTONS-1:0] o_held,
  output logic [NUM_BUTTONS-1:0] o_press,
  output logic [NUM_BUTTONS-1:0] o_release,
  output logic [NUM_BUTTONS-1:0] o_long_press,
  output logic [NUM_BUTTONS-1:0] o_repeat_evt
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESSED,
    ST_LONG
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LONG_LAST = CNT_WIDTH'(LONG_CYCLES - 1);

  // Reject thresholds the counter cannot reach or that would fire on entry.
  if (LONG_CYCLES < 2 || REPEAT_CYCLES < 2 ||
      (CNT_WIDTH < 32 && (LONG_CYCLES   > (2**CNT_WIDTH) - 1 ||
                          REPEAT_CYCLES > (2**CNT_WIDTH) - 1))) begin : g_bad_param
    $error("button_event_decoder: LONG_CYCLES/REPEAT_CYCLES out of range");
  end

  logic [NUM_BUTTONS-1:0] r_s;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_s <= '0;
    else       r_s <= i_buttons;
  end

  assign o_held = r_s;

  for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_lane
    state_t               r_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_press;
    logic                 r_release;
    logic                 r_long;
`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_WIDTH-1:0] REPEAT_LAST = CNT_WIDTH'(REPEAT_CYCLES - 1);
    logic                 r_repeat;
`endif

    // Release is tested before any threshold so it wins a same-cycle race.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_state   <= ST_IDLE;
        r_cnt     <= '0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_long    <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        r_repeat  <= 1'b0;
`endif
      end else begin
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_long    <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        r_repeat  <= 1'b0;
`endif
        case (r_state)
          ST_IDLE: begin
            if (r_s[gi]) begin
              r_press <= 1'b1;
              r_cnt   <= '0;
              r_state <= ST_PRESSED;
            end
          end
          ST_PRESSED: begin
            if (!r_s[gi]) begin
              r_release <= 1'b1;
              r_cnt     <= '0;
              r_state   <= ST_IDLE;
            end else if (r_cnt == LONG_LAST) begin
              r_long  <= 1'b1;
              r_cnt   <= '0;
              r_state <= ST_LONG;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_LONG: begin
            if (!r_s[gi]) begin
              r_release <= 1'b1;
              r_cnt     <= '0;
              r_state   <= ST_IDLE;
            end else begin
`ifdef BTN_AUTOREPEAT_EN
              if (r_cnt == REPEAT_LAST) begin
                r_repeat <= 1'b1;
                r_cnt    <= '0;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
`else
              r_cnt <= '0;
`endif
            end
          end
          default: begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end
        endcase
      end
    end

    assign o_press[gi]      = r_press;
    assign o_release[gi]    = r_release;
    assign o_long_press[gi] = r_long;
`ifdef BTN_AUTOREPEAT_EN
    assign o_repeat_evt[gi] = r_repeat;
`endif
  end

`ifndef BTN_AUTOREPEAT_EN
  assign o_repeat_evt = '0;
`endif

endmodule

// File: doc/button_event_decoder.md
# button_event_decoder

Converts the debounced button levels from the debounce wrapper into one-cycle event pulses for the stopwatch control logic: press, release, long-press and optional auto-repeat per button. It sits between the debounce wrapper output vector and the stopwatch control FSM. Each button has an independent hold counter and a three-state FSM.

## Interface
- NUM_BUTTONS, 5, number of button lanes (index 0 = START).
- CNT_WIDTH, 27, hold-counter width.
- LONG_CYCLES, 100_000_000, hold time to long-press, in clk cycles (1 s at 100 MHz); legal range 2 .. 2^CNT_WIDTH-1.
- REPEAT_CYCLES, 20_000_000, auto-repeat period in clk cycles; legal range 2 .. 2^CNT_WIDTH-1.
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- buttons  in  NUM_BUTTONS  debounced levels from the debounce wrapper, 1 = pressed.
- held  out  NUM_BUTTONS  registered copy of buttons.
- press  out  NUM_BUTTONS  one-cycle pulse on press.
- release  out  NUM_BUTTONS  one-cycle pulse on release.
- long_press  out  NUM_BUTTONS  one-cycle pulse when the hold reaches LONG_CYCLES.
- repeat_evt  out  NUM_BUTTONS  one-cycle auto-repeat pulse; constant 0 unless BTN_AUTOREPEAT_EN is defined.

## Operation
- Per lane i: sample register s[i] <= buttons[i]; held[i] = s[i].
- Per-lane FSM states: IDLE, PRESSED, LONG.
- IDLE: on s[i]=1, assert press[i] next edge, clear cnt[i], go PRESSED.
- PRESSED: cnt[i] increments each cycle while s[i]=1. At cnt[i] = LONG_CYCLES-1, assert long_press[i], clear cnt[i], go LONG. On s[i]=0, assert release[i], go IDLE.
- LONG: with BTN_AUTOREPEAT_EN, cnt[i] counts. At cnt[i] = REPEAT_CYCLES-1, assert repeat_evt[i] and clear cnt[i]. Without the macro, cnt[i] holds at 0. On s[i]=0, assert release[i] and go IDLE.
- Release has priority: if s[i] falls in the same cycle the counter hits a threshold, only release[i] fires.
- At most one of press/release/long_press/repeat_evt is high per lane per cycle. Lanes are fully independent, and simultaneous events on different lanes all fire.
- Counter never wraps, because it is cleared at each threshold.
- Reset: s, cnt, FSM (IDLE) and all outputs go to 0 immediately. If a button is still high after rst deasserts, a fresh press is generated. No release is emitted for a hold interrupted by reset.

## Timing
- buttons[i] rises before edge k: s[i]/held[i] high after edge k, press[i] high for exactly cycle k+1..k+2.
- long_press[i] rises exactly LONG_CYCLES edges after press[i] rises, if the button is held continuously.
- First repeat_evt[i] rises REPEAT_CYCLES edges after long_press[i] rises, then every REPEAT_CYCLES edges.
- buttons[i] falls before edge j: release[i] high for the cycle after edge j+1.
- A press of one clk cycle still yields press then release on consecutive cycles.
- All outputs are registered and there is no combinational path from buttons to outputs.

## Configuration
- BTN_AUTOREPEAT_EN defined: LONG state runs the repeat counter and drives repeat_evt.
- BTN_AUTOREPEAT_EN undefined: repeat logic is removed, repeat_evt is tied to 0, and LONG waits only for release. press, release, long_press and their timing are identical in both builds.

## Test plan
Bench parameters: LONG_CYCLES=10, REPEAT_CYCLES=4, 10 ns clock, stimulus offset from clock edges.
- Reset: hold rst=1 with buttons=5'b11111 -> all outputs 0. Deassert rst -> press=5'b11111 for one cycle two edges later, with no release.
- Short press: buttons[0] high for 5 cycles -> one press[0] pulse, then one release[0] pulse 5 cycles later, and no long_press.
- Long press with BTN_AUTOREPEAT_EN: buttons[1] held for 25 cycles -> press[1]; long_press[1] 10 cycles after press; repeat_evt[1] 4, 8 and 12 cycles after long_press; release[1] on drop. Without the macro: no repeat_evt.
- Threshold race: buttons[2] drops in the cycle where the counter reaches 9 -> release[2] only, no long_press[2].
- Simultaneous lanes: buttons[3] rises as buttons[4] falls -> press[3] and release[4] in the same cycle.
- Reset mid-hold: rst pulses during LONG on lane 0 -> outputs clear immediately and no release is emitted. After rst, press[0] is emitted again and long_press[0] follows 10 cycles later.
